// File: rtl/pdec_bitonic_sort_ctrl.sv
// Sequential 16-lane bitonic sorter for polar decoder path metrics.
// One network stage per clock; metrics travel with their original lane indices.
module pdec_bitonic_sort_ctrl #(
  parameter int WID_D = 10,
  parameter int WID_I = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [WID_D*16-1:0]   in_data,
  input  logic                  in_order,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [WID_D*16-1:0]   out_data,
  output logic [WID_I*16-1:0]   out_idx,
  output logic                  busy
);

  localparam int LANES  = 16;
  localparam int PAIRS  = 8;
  localparam int NSTAGE = 10;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       stage;
  logic             order_reg;
  logic [WID_D-1:0] data_reg [LANES];
  logic [WID_I-1:0] idx_reg  [LANES];
  logic [WID_D-1:0] data_nxt [LANES];
  logic [WID_I-1:0] idx_nxt  [LANES];
  logic [2:0]       k_cur;
  logic [1:0]       j_cur;

  // Lower lane of pair p at distance 2^j.
  function automatic logic [3:0] pair_lo(input logic [2:0] p, input logic [1:0] j);
    logic [3:0] pe;
    logic [3:0] mask;
    pe   = {1'b0, p};
    mask = (4'd1 << j) - 4'd1;
    return ((pe >> j) << (3'(j) + 3'd1)) | (pe & mask);
  endfunction

  always_comb begin : sched
    k_cur = 3'd1;
    j_cur = 2'd0;
    case (stage)
      4'd0:    begin k_cur = 3'd1; j_cur = 2'd0; end
      4'd1:    begin k_cur = 3'd2; j_cur = 2'd1; end
      4'd2:    begin k_cur = 3'd2; j_cur = 2'd0; end
      4'd3:    begin k_cur = 3'd3; j_cur = 2'd2; end
      4'd4:    begin k_cur = 3'd3; j_cur = 2'd1; end
      4'd5:    begin k_cur = 3'd3; j_cur = 2'd0; end
      4'd6:    begin k_cur = 3'd4; j_cur = 2'd3; end
      4'd7:    begin k_cur = 3'd4; j_cur = 2'd2; end
      4'd8:    begin k_cur = 3'd4; j_cur = 2'd1; end
      4'd9:    begin k_cur = 3'd4; j_cur = 2'd0; end
      default: begin k_cur = 3'd1; j_cur = 2'd0; end
    endcase
  end

  // Permute into pairs, compare-exchange, write back to lanes lo/hi.
  always_comb begin : cmp_exch
    logic [3:0] lo;
    logic [3:0] hi;
    logic       dir;
    logic       swap;
    // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
    data_nxt = data_reg;
    idx_nxt  = idx_reg;
    lo   = '0;
    hi   = '0;
    dir  = 1'b0;
    swap = 1'b0;
    for (int p = 0; p < PAIRS; p++) begin
      lo   = pair_lo(3'(p), j_cur);
      hi   = lo + (4'd1 << j_cur);
      // Lane bit 4 does not exist, so the final merge follows order_reg alone.
      dir  = order_reg ^ ((k_cur == 3'd4) ? 1'b0 : lo[k_cur[1:0]]);
      swap = dir ? (data_reg[lo] > data_reg[hi]) : (data_reg[lo] < data_reg[hi]);
      data_nxt[lo] = swap ? data_reg[hi] : data_reg[lo];
      data_nxt[hi] = swap ? data_reg[lo] : data_reg[hi];
      idx_nxt[lo]  = swap ? idx_reg[hi]  : idx_reg[lo];
      idx_nxt[hi]  = swap ? idx_reg[lo]  : idx_reg[hi];
    end
  end

  // NOTE: blocking '=' only in comb blocks; clocked state uses '<=' so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_vld)                     state_nxt = SORT;
      SORT:    if (stage == 4'(NSTAGE - 1))    state_nxt = DONE;
      DONE:    if (out_rdy)                    state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // NOTE: the lane registers are reset so an aborted sort never leaves a visible remnant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      order_reg <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        data_reg[n] <= '0;
        idx_reg[n]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (in_vld) begin
          for (int n = 0; n < LANES; n++) begin
            data_reg[n] <= in_data[n*WID_D +: WID_D];
            idx_reg[n]  <= WID_I'(n);
          end
          order_reg <= in_order;
          stage     <= '0;
        end
        SORT: begin
          data_reg <= data_nxt;
          idx_reg  <= idx_nxt;
          stage    <= (stage == 4'(NSTAGE - 1)) ? 4'd0 : stage + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign busy    = (state != IDLE);

  for (genvar n = 0; n < LANES; n++) begin : g_out
    assign out_data[n*WID_D +: WID_D] = data_reg[n];
    assign out_idx[n*WID_I +: WID_I]  = idx_reg[n];
  end

endmodule

// File: tb/tb_pdec_bitonic_sort_ctrl.sv
// Self-checking bench for pdec_bitonic_sort_ctrl: directed table, corner sequences,
// and a randomized scoreboard run against a software sort model.
module tb_pdec_bitonic_sort_ctrl;

  localparam int WD = 10;
  localparam int WI = 5;
  localparam int LN = 16;

  logic              clk;
  logic              rst_n;
  logic              in_vld;
  logic              in_rdy;
  logic [WD*LN-1:0]  in_data;
  logic              in_order;
  logic              out_vld;
  logic              out_rdy;
  logic [WD*LN-1:0]  out_data;
  logic [WI*LN-1:0]  out_idx;
  logic              busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [WD*LN-1:0] din;
    logic             ord;
  } sb_t;

  typedef struct {
    logic [WD*LN-1:0] din;
    logic             ord;
    logic [WD*LN-1:0] exp_d;
    logic [WI*LN-1:0] exp_i;
  } vec_t;

  sb_t  sb[$];
  sb_t  e_mon;
  vec_t tbl[6];

  pdec_bitonic_sort_ctrl #(.WID_D(WD), .WID_I(WI)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .in_order (in_order),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WD*LN-1:0] model_sort(input logic [WD*LN-1:0] d, input logic ord);
    logic [WD-1:0]    a [LN];
    logic [WD-1:0]    t;
    logic [WD*LN-1:0] r;
    for (int n = 0; n < LN; n++) a[n] = d[n*WD +: WD];
    for (int i = 1; i < LN; i++)
      for (int j = i; j > 0; j--)
        if (ord ? (a[j-1] > a[j]) : (a[j-1] < a[j])) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
    for (int n = 0; n < LN; n++) r[n*WD +: WD] = a[n];
    return r;
  endfunction

  task automatic compare_out(input sb_t e);
    logic [15:0]      seen;
    logic [WI*LN-1:0] ident;
    logic [WI-1:0]    ix;
    logic             all_eq;
    int               bad;
    seen = '0; bad = 0; all_eq = 1'b1; ident = '0;
    for (int n = 0; n < LN; n++) begin
      ix = out_idx[n*WI +: WI];
      ident[n*WI +: WI] = WI'(n);
      if (ix > 15) bad++;
      else begin
        seen[ix[3:0]] = 1'b1;
        if (out_data[n*WD +: WD] !== e.din[ix[3:0]*WD +: WD]) bad++;
      end
      if (e.din[n*WD +: WD] != e.din[WD-1:0]) all_eq = 1'b0;
    end
    check("sorted_data", out_data, model_sort(e.din, e.ord));
    check("idx_perm", seen, 16'hFFFF);
    check("idx_data_link", bad, 0);
    if (all_eq) check("tie_idx_identity", out_idx, ident);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_vld && in_rdy) sb.push_back('{din: in_data, ord: in_order});
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) check("sb_unexpected_output", 1'b1, 1'b0);
        else begin
          e_mon = sb.pop_front();
          compare_out(e_mon);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [WD*LN-1:0] d, input logic o);
    int t;
    t = 0;
    in_data = d; in_order = o; in_vld = 1'b1;
    while (!in_rdy && t < 200) begin step(); t++; end
    check("accept_timeout", t < 200, 1'b1);
    step();
    in_vld   = 1'b0;
    in_data  = {5{$urandom()}};
    in_order = ~o;
  endtask

  // Waits for out_vld; returns cycles after the accept edge and whether in_rdy leaked.
  task automatic wait_out(output int lat, output logic rdy_leak);
    lat = 0; rdy_leak = 1'b0;
    while (!out_vld && lat < 100) begin
      if (in_rdy) rdy_leak = 1'b1;
      step();
      lat++;
    end
  endtask

  task automatic run_directed(input vec_t v, input string tag);
    int   lat;
    logic leak;
    send(v.din, v.ord);
    wait_out(lat, leak);
    // out_vld in the 11th cycle after the accept cycle = 10 edges past the accept edge.
    check({tag, "_latency"}, lat, 10);
    check({tag, "_in_rdy_sort"}, leak, 1'b0);
    check({tag, "_in_rdy_done"}, in_rdy, 1'b0);
    check({tag, "_data"}, out_data, v.exp_d);
    check({tag, "_idx"}, out_idx, v.exp_i);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check({tag, "_vld_drop"}, out_vld, 1'b0);
    check({tag, "_rdy_back"}, in_rdy, 1'b1);
  endtask

  initial begin
    logic [WD*LN-1:0] d, x;
    logic [WI*LN-1:0] ix, idn, rev;
    logic             stable, leak;
    int               lat, t;

    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_order = 1'b0; out_rdy = 1'b0;

    for (int n = 0; n < LN; n++) begin
      idn[n*WI +: WI] = WI'(n);
      rev[n*WI +: WI] = WI'(15 - n);
      d[n*WD +: WD]   = WD'(15 - n);
      x[n*WD +: WD]   = WD'(n);
    end
    tbl[0] = '{din: d,            ord: 1'b1, exp_d: x,            exp_i: rev};
    tbl[1] = '{din: x,            ord: 1'b0, exp_d: d,            exp_i: rev};
    tbl[2] = '{din: {LN{10'h3FF}}, ord: 1'b0, exp_d: {LN{10'h3FF}}, exp_i: idn};
    tbl[3] = '{din: {LN{10'h3FF}}, ord: 1'b1, exp_d: {LN{10'h3FF}}, exp_i: idn};
    tbl[4] = '{din: '0,           ord: 1'b0, exp_d: '0,           exp_i: idn};
    tbl[5] = '{din: '0,           ord: 1'b1, exp_d: '0,           exp_i: idn};

    #3;
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_idx", out_idx, '0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_directed(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: DONE holds, and a DONE-cycle in_vld is not accepted.
    send(tbl[0].din, tbl[0].ord);
    wait_out(lat, leak);
    d = out_data; ix = out_idx; stable = 1'b1; leak = 1'b0;
    in_vld = 1'b1; in_data = tbl[1].din; in_order = 1'b0;
    repeat (20) begin
      step();
      if (!out_vld || out_data !== d || out_idx !== ix) stable = 1'b0;
      if (in_rdy) leak = 1'b1;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_in_rdy_low", leak, 1'b0);
    check("bp_data", d, tbl[0].exp_d);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0; in_vld = 1'b0;
    check("bp_vld_drop", out_vld, 1'b0);
    check("bp_rdy_back", in_rdy, 1'b1);
    check("bp_no_accept_in_done", busy, 1'b0);

    // Reset during stage 5, then a clean sort.
    send(tbl[1].din, tbl[1].ord);
    repeat (5) step();
    check("pre_abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_out_vld", out_vld, 1'b0);
    check("abort_in_rdy", in_rdy, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_data", out_data, '0);
    check("abort_idx", out_idx, '0);
    step(); step();
    check("abort_hold_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    run_directed(tbl[0], "post_abort");

    // Randomized traffic with gaps and backpressure; ties forced on some vectors.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) step();
      for (int n = 0; n < LN; n++)
        d[n*WD +: WD] = WD'($urandom_range(0, (i % 3 == 0) ? 3 : 1023));
      send(d, 1'($urandom_range(0, 1)));
    end
    t = 0;
    while (sb.size() != 0 && t < 1000) begin step(); t++; end
    check("sb_drain", sb.size(), 0);
    rand_rdy = 1'b0;
    out_rdy  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdec_bitonic_sort_ctrl.md
Name: pdec_bitonic_sort_ctrl

Overview:
- Sequential 16-lane bitonic sorter for polar decoder path metrics: accepts 16 metrics, sorts them with their lane indices, returns the sorted vector.
- Acts as the driver of the existing 8-pair compare-exchange unit: for each network stage it permutes lanes into pairs, generates the per-pair sort_ind, runs the compare-exchange, then inverse-permutes and registers the result.
- One stage per clock, 10 stages per sort; valid/ready handshake on both sides.
- Sits between path-metric update and list pruning.

Parameters:
- WID_D, 10, metric width (unsigned).
- WID_I, 5, index width; must be >= 4.

Ports:
- clk  input  1  clock; all registers rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vld  input  1  input vector valid.
- in_rdy  output  1  block can accept a vector.
- in_data  input  WID_D*16  lane n at [n*WID_D +: WID_D].
- in_order  input  1  0: descend (lane 0 largest); 1: ascend (lane 0 smallest).
- out_vld  output  1  sorted vector valid.
- out_rdy  input  1  downstream accepts the vector.
- out_data  output  WID_D*16  sorted metrics, lane n at [n*WID_D +: WID_D].
- out_idx  output  WID_I*16  original input lane of each output lane, lane n at [n*WID_I +: WID_I].
- busy  output  1  high in SORT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, stage counter=0, data/idx/order registers=0, out_vld=0, busy=0. in_rdy is decoded from state, so it reads 1 during reset.
- State machine (registered state, combinational decode):
  - IDLE: in_rdy=1. On in_vld&in_rdy:
    - data_reg <= in_data.
    - idx_reg lane n <= n, zero-extended to WID_I.
    - order_reg <= in_order.
    - stage counter <= 0; state -> SORT.
  - SORT: in_rdy=0, out_vld=0. Each cycle, apply stage s (counter value) to data_reg/idx_reg and increment the counter. At s=9, the update goes to DONE and clears the counter.
  - DONE: out_vld=1. out_data/out_idx driven directly from the registers, held stable until the handshake. On out_rdy -> IDLE.
  - No input acceptance in DONE, even if out_rdy is high in that cycle.
- Latency: accept edge E; SORT stage updates on edges E+1..E+10; out_vld high from the cycle after E+10. If out_rdy is held high, throughput is one vector per 12 cycles.
- Stage schedule, s=0..9, as (k,j): (1,0) (2,1) (2,0) (3,2) (3,1) (3,0) (4,3) (4,2) (4,1) (4,0).
- Pairing at distance d=2^j:
  - Pair p=0..7 has lower lane lo = ((p>>j)<<(j+1)) | (p & (d-1)) and hi = lo+d.
  - lo feeds element 0 of the pair, hi feeds element 1.
- Direction: sort_ind[p] = order_reg XOR bit k of lo. Bit 4 is always 0, so the final merge follows order_reg.
- Compare-exchange semantics per pair:
  - Ascend: swap if a0>a1. Descend: swap if a0<a1.
  - Equal values hold. Data and idx move together.
  - Comparison is unsigned over WID_D.
- Inverse permutation writes each pair's outputs back to lanes lo/hi of the registers.
- Ties: no stability guarantee beyond the fixed network. The result is deterministic, and out_data lane n equals in_data lane out_idx[n].
- in_vld/in_data/in_order are ignored outside IDLE. in_data changes after acceptance do not affect the sort.
- Reset mid-sort or in DONE: abort immediately, return to the IDLE reset values, and emit no partial vector.
- out_rdy high while not DONE: no effect.

Test Plan:
- Ascend, in_data lane n = 15-n, in_order=1: out_data lane n = n, out_idx lane n = 15-n. out_vld rises exactly 11 cycles after the accept cycle.
- Descend, in_data lane n = n, in_order=0: out_data lane n = 15-n, out_idx lane n = 15-n. in_rdy must be 0 for all 10 SORT cycles plus DONE.
- All lanes = 10'h3FF and all lanes = 0, both orders: out_data unchanged. out_idx equals the fixed network permutation; with all-equal data there are no swaps, so out_idx lane n = n.
- Backpressure: out_rdy=0 for 20 cycles after out_vld: outputs stable, in_rdy=0. Then out_rdy=1 for one cycle: out_vld drops next cycle and in_rdy=1.
- Reset asserted at SORT stage 5: all outputs at reset values while rst_n is low. A new vector after release sorts correctly with no remnant of the aborted vector.
- 1000 random vectors with random in_order and random in_vld/out_rdy gaps, compared against a reference model:
  - out_data is monotonic in the requested order.
  - out_idx is a permutation of 0..15.
  - out_data[n] == in_data[out_idx[n]] for every lane.
